instr_prefetch_unit: RTL and testbench

//  Fetch stage upstream of the single-cycle core's decode. Reads big-endian 4-byte instructions

---
 rtl/proc_pkg.sv | 11 +
 rtl/pfu_fifo.sv | 50 +++++
 rtl/instr_prefetch_unit.sv | 99 +++++++++
 tb/tb_instr_prefetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared fetch-path constants, byte-state enum and fetch entry struct
package proc_pkg;
   localparam int INST_W  = 32;
   localparam int BYTE_W  = 8;
   localparam int PC_STEP = 4;
   typedef enum logic [1:0] {B0, B1, B2, B3} byte_state_e;
   typedef struct packed {
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] word;
   } fetch_entry_t;
endpackage

// File: rtl/pfu_fifo.sv
// pfu_fifo: DEPTH-entry queue of {pc, word} fetch entries with push/pop/flush.
//  clk, rst_n       clock, async active-low reset
//  push_i, pop_i    enqueue din_i / dequeue head (both allowed in one edge)
//  flush_i          empties the queue, overrides push and pop
//  din_i, dout_o    entry in / head entry out
//  full_o, empty_o, count_o  occupancy status
module pfu_fifo
   import proc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   input  fetch_entry_t            din_i,
   output fetch_entry_t            dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
   assign dout_o  = mem_q[rd_q];
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: fetches big-endian 4-byte words one byte per cycle and queues {pc, word} for decode.
//  clk, rst_n                 clock, async active-low reset
//  imem_rd, imem_addr         byte read strobe and address
//  imem_data                  byte returned in the same cycle
//  redirect, redirect_pc      flush the queue and restart at redirect_pc (word aligned)
//  inst_valid/inst/inst_pc    queue head, consumed when inst_ready is high
//  q_count                    queued entries
//  PFU_STATS_EN defined: adds saturating stall_cnt and redirect_cnt outputs
module instr_prefetch_unit
   import proc_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_rd,
   output logic [ADDR_W-1:0]       imem_addr,
   input  logic [BYTE_W-1:0]       imem_data,
   input  logic                    redirect,
   input  logic [INST_W-1:0]       redirect_pc,
   output logic                    inst_valid,
   output logic [INST_W-1:0]       inst,
   output logic [INST_W-1:0]       inst_pc,
   input  logic                    inst_ready,
   output logic [$clog2(DEPTH):0]  q_count
`ifdef PFU_STATS_EN
   ,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             redirect_cnt
`endif
);
   byte_state_e       state_q, state_d;
   logic [INST_W-1:0] pc_q, pc_d, word_q, word_d, word_nxt;
   logic [1:0]        k;
   logic              stall, push, pop, full, empty;
   fetch_entry_t      din, head;
   assign stall     = full && !(inst_valid && inst_ready);
   assign imem_rd   = rst_n && !stall;
   assign k         = state_q;
   assign imem_addr = pc_q[ADDR_W-1:0] + ADDR_W'(k);
   // byte k lands at bit 8*(3-k); for a 2-bit k, 3-k is simply ~k
   assign word_nxt  = word_q | (INST_W'(imem_data) << {~k, 3'b000});
   assign push      = imem_rd && state_q == B3 && !redirect;
   assign pop       = inst_valid && inst_ready && !redirect;
   assign din       = '{pc: pc_q, word: word_nxt};
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      word_d  = word_q;
      if (redirect) begin
         state_d = B0;
         pc_d    = redirect_pc & ~32'd3;
         word_d  = '0;
      end else if (!stall) begin
         state_d = byte_state_e'(k + 2'd1);
         word_d  = (state_q == B3) ? '0 : word_nxt;
         pc_d    = (state_q == B3) ? pc_q + 32'(PC_STEP) : pc_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= B0;
         pc_q    <= RESET_PC;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
      end
   end
   pfu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .din_i   (din),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (q_count)
   );
   assign inst_valid = !empty;
   assign inst       = head.word;
   assign inst_pc    = head.pc;
`ifdef PFU_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if (redirect && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: directed vectors and corner sequences for instr_prefetch_unit.
module tb_instr_prefetch_unit;
   logic        clk = 0, rst_n = 0, redirect = 0, inst_ready = 0;
   logic [31:0] redirect_pc = '0;
   logic        imem_rd, inst_valid;
   logic [4:0]  imem_addr;
   logic [7:0]  imem_data;
   logic [31:0] inst, inst_pc;
   logic [2:0]  q_count;
`ifdef PFU_STATS_EN
   logic [31:0] stall_cnt, redirect_cnt;
`endif
   int          n_chk = 0, n_err = 0, n_pop = 0, pop_base;
   logic [31:0] exp_pc = '0;

   typedef struct {
      logic        ready;
      logic        rd;
      logic [4:0]  addr;
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;
   // memory content: byte value equals its address
   assign imem_data = {3'b000, imem_addr};

   instr_prefetch_unit #(.DEPTH(4), .ADDR_W(5), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_rd     (imem_rd),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .q_count     (q_count)
`ifdef PFU_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .redirect_cnt(redirect_cnt)
`endif
   );

   function automatic logic [31:0] exp_word(logic [31:0] pc);
      logic [4:0] a;
      a = pc[4:0];
      return {3'b0, a, 3'b0, 5'(a + 5'd1), 3'b0, 5'(a + 5'd2), 3'b0, 5'(a + 5'd3)};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_rd"}, imem_rd, 0);
      chk({tag, "_valid"}, inst_valid, 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_pc"}, inst_pc, 0);
      chk({tag, "_cnt"}, q_count, 0);
`ifdef PFU_STATS_EN
      chk({tag, "_stall_cnt"}, stall_cnt, 0);
      chk({tag, "_redir_cnt"}, redirect_cnt, 0);
`endif
   endtask

   task automatic reset_dut;
      @(posedge clk);
      #1;
      rst_n = 0;
      redirect = 0;
      inst_ready = 0;
      exp_pc = '0;
      #1;
      check_zero("rst");
      tick;
      rst_n = 1;
   endtask

   // in-order scoreboard: every accepted head must be the next sequential word
   always @(negedge clk) begin
      if (rst_n && inst_valid && inst_ready && !redirect) begin
         chk("pop_pc", inst_pc, exp_pc);
         chk("pop_word", inst, exp_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_pop++;
      end
   end

   initial begin
      tbl[0] = '{1, 1, 5'd0, 0, 32'h0, 32'h0, 3'd0};
      tbl[1] = '{1, 1, 5'd1, 0, 32'h0, 32'h0, 3'd0};
      tbl[2] = '{1, 1, 5'd2, 0, 32'h0, 32'h0, 3'd0};
      tbl[3] = '{1, 1, 5'd3, 0, 32'h0, 32'h0, 3'd0};
      tbl[4] = '{1, 1, 5'd4, 1, 32'h00010203, 32'h0, 3'd1};
      tbl[5] = '{1, 1, 5'd5, 0, 32'h0, 32'h0, 3'd0};
      tbl[6] = '{1, 1, 5'd6, 0, 32'h0, 32'h0, 3'd0};
      tbl[7] = '{1, 1, 5'd7, 0, 32'h0, 32'h0, 3'd0};
      tbl[8] = '{1, 1, 5'd8, 1, 32'h04050607, 32'h4, 3'd1};
      tbl[9] = '{1, 1, 5'd9, 0, 32'h0, 32'h0, 3'd0};

      // streaming from reset with decode always ready
      reset_dut;
      for (int i = 0; i < 10; i++) begin
         inst_ready = tbl[i].ready;
         #1;
         chk("vec_rd", imem_rd, tbl[i].rd);
         chk("vec_addr", imem_addr, tbl[i].addr);
         chk("vec_valid", inst_valid, tbl[i].valid);
         chk("vec_cnt", q_count, tbl[i].cnt);
         if (tbl[i].valid) begin
            chk("vec_inst", inst, tbl[i].inst);
            chk("vec_pc", inst_pc, tbl[i].pc);
         end
         tick;
      end

      // backpressure until full, then drain in order
      reset_dut;
      repeat (40) tick;
      #1;
      chk("full_cnt", q_count, 4);
      chk("full_rd", imem_rd, 0);
      chk("full_valid", inst_valid, 1);
      chk("full_inst", inst, 32'h00010203);
      chk("full_pc", inst_pc, 0);
`ifdef PFU_STATS_EN
      chk("stall_cnt", stall_cnt, 24);
`endif
      pop_base = n_pop;
      inst_ready = 1;
      #1;
      chk("resume_rd", imem_rd, 1);
      chk("resume_addr", imem_addr, 5'h10);
      repeat (3) tick;
      #1;
      chk("b3_addr", imem_addr, 5'h13);
      chk("b3_cnt", q_count, 1);
      tick;
      #1;
      chk("pushpop_cnt", q_count, 1);
      repeat (20) tick;
      chk("drain_pops", n_pop - pop_base, 9);

      // redirect during B2 with two words queued
      reset_dut;
      repeat (10) tick;
      #1;
      chk("pre_redir_cnt", q_count, 2);
      chk("pre_redir_addr", imem_addr, 5'h0A);
      redirect = 1;
      redirect_pc = 32'h13;
      tick;
      redirect = 0;
      inst_ready = 1;
      exp_pc = 32'h10;
      #1;
      chk("redir_valid", inst_valid, 0);
      chk("redir_cnt", q_count, 0);
      chk("redir_rd", imem_rd, 1);
      chk("redir_addr", imem_addr, 5'h10);
`ifdef PFU_STATS_EN
      chk("redirect_cnt1", redirect_cnt, 1);
`endif
      repeat (4) tick;
      #1;
      chk("redir_word_valid", inst_valid, 1);
      chk("redir_word", inst, 32'h10111213);
      chk("redir_word_pc", inst_pc, 32'h10);

      // address wrap past the top of memory
      redirect = 1;
      redirect_pc = 32'h1C;
      exp_pc = 32'h1C;
      tick;
      redirect = 0;
      #1;
      chk("wrap_start_addr", imem_addr, 5'h1C);
      chk("wrap_start_valid", inst_valid, 0);
      repeat (4) tick;
      #1;
      chk("wrap_word", inst, 32'h1C1D1E1F);
      chk("wrap_word_pc", inst_pc, 32'h1C);
      chk("wrap_addr", imem_addr, 5'h00);
      repeat (4) tick;
      #1;
      chk("wrap_next_word", inst, 32'h00010203);
      chk("wrap_next_pc", inst_pc, 32'h20);

      // back-to-back redirects: the last one wins
      redirect = 1;
      redirect_pc = 32'h05;
      tick;
      redirect_pc = 32'h0A;
      exp_pc = 32'h08;
      tick;
      redirect = 0;
      #1;
      chk("b2b_addr", imem_addr, 5'h08);
      chk("b2b_valid", inst_valid, 0);
`ifdef PFU_STATS_EN
      chk("redirect_cnt4", redirect_cnt, 4);
`endif

      // asynchronous reset in the middle of B2
      repeat (2) tick;
      #2;
      rst_n = 0;
      exp_pc = '0;
      #1;
      check_zero("midrst");
      tick;
      rst_n = 1;
      repeat (4) tick;
      #1;
      chk("post_rst_valid", inst_valid, 1);
      chk("post_rst_inst", inst, 32'h00010203);
      chk("post_rst_pc", inst_pc, 0);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
